// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the load/store unit: access-size encodings,
// controller states and lane widths.
package mem_lsu_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StResp
  } lsu_state_e;

endpackage

// File: rtl/mem_lsu_if.sv
// Request/response and data-memory signals of the load/store unit.
// master: CPU datapath plus data memory; slave: the load/store unit.
interface mem_lsu_if #(
  parameter int unsigned ADDRESSWIDTH = 32,
  parameter int unsigned WIDTH        = 32
);

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [1:0]              req_size;
  logic                    req_signed;
  logic [ADDRESSWIDTH-1:0] req_addr;
  logic [WIDTH-1:0]        req_wdata;
  logic                    resp_valid;
  logic [WIDTH-1:0]        resp_rdata;
  logic                    resp_err;
  logic [ADDRESSWIDTH-1:0] mem_address;
  logic                    mem_MemWrite;
  logic                    mem_MemRead;
  logic [WIDTH-1:0]        mem_writeData;
  logic [WIDTH-1:0]        mem_readData;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_readData,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_address, mem_MemWrite, mem_MemRead, mem_writeData
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_readData,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_address, mem_MemWrite, mem_MemRead, mem_writeData
  );

endinterface

// File: rtl/mem_lsu_lanes.sv
// Little-endian lane logic: extracts and extends load data from a memory word,
// and merges sub-word store data into the old word for read-modify-write.
module mem_lsu_lanes
  import mem_lsu_pkg::*;
(
  input  logic [1:0]        addr_lo,
  input  size_e             size,
  input  logic              is_signed,
  input  logic [WORD_W-1:0] rd_word,
  input  logic [WORD_W-1:0] st_data,
  output logic [WORD_W-1:0] ld_data,
  output logic [WORD_W-1:0] st_word
);

  logic [BYTE_W-1:0] byte_lane;
  logic [HALF_W-1:0] half_lane;

  // Load path: select the addressed lane, then sign- or zero-extend it.
  always_comb begin
    byte_lane = rd_word[{addr_lo, 3'b000} +: BYTE_W];
    half_lane = rd_word[{addr_lo[1], 4'b0000} +: HALF_W];
    ld_data   = rd_word;
    case (size)
      SZ_BYTE: ld_data = {{(WORD_W - BYTE_W){is_signed & byte_lane[BYTE_W-1]}}, byte_lane};
      SZ_HALF: ld_data = {{(WORD_W - HALF_W){is_signed & half_lane[HALF_W-1]}}, half_lane};
      default: ld_data = rd_word;
    endcase
  end

  // Store path: replace only the target lane(s) of the old word.
  always_comb begin
    st_word = rd_word;
    case (size)
      SZ_BYTE: st_word[{addr_lo, 3'b000} +: BYTE_W] = st_data[BYTE_W-1:0];
      SZ_HALF: st_word[{addr_lo[1], 4'b0000} +: HALF_W] = st_data[HALF_W-1:0];
      default: st_word = st_data;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator: turns byte-addressed load/store requests into
// word-addressed memory cycles, with read-modify-write for sub-word stores.
// Optional macro MEM_LSU_ALIGN_CHECK_EN enables misalignment / illegal-size
// errors; without it addresses are force-aligned and size 11 acts as word.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned ADDRESSWIDTH = 32,
  parameter int unsigned WIDTH        = 32
) (
  input logic      clk,
  input logic      reset_n,
  mem_lsu_if.slave bus
);

  lsu_state_e              state_q, state_d;
  logic [1:0]              addr_lo_q;
  size_e                   size_q;
  logic                    signed_q;
  logic                    write_q;
  logic [WIDTH-1:0]        wdata_q;
  logic                    err_q;
  logic [ADDRESSWIDTH-1:0] waddr_q;
  logic [WIDTH-1:0]        wword_q;
  logic [WIDTH-1:0]        rdata_q;

  logic                    accept;
  size_e                   acc_size;
  logic [ADDRESSWIDTH-1:0] acc_addr;
  logic                    acc_err;
  logic [WIDTH-1:0]        ld_data;
  logic [WIDTH-1:0]        st_word;

  assign accept = bus.req_valid && (state_q == StIdle);

  // Decode the incoming request: effective size, address and error flag.
  always_comb begin
    acc_size = size_e'(bus.req_size);
    acc_addr = bus.req_addr;
    acc_err  = 1'b0;
`ifdef MEM_LSU_ALIGN_CHECK_EN
    case (size_e'(bus.req_size))
      SZ_HALF: acc_err = bus.req_addr[0];
      SZ_WORD: acc_err = |bus.req_addr[1:0];
      SZ_ILL:  acc_err = 1'b1;
      default: acc_err = 1'b0;
    endcase
`else
    case (size_e'(bus.req_size))
      SZ_HALF: acc_addr[0] = 1'b0;
      SZ_WORD, SZ_ILL: begin
        acc_size      = SZ_WORD;
        acc_addr[1:0] = 2'b00;
      end
      default: acc_addr = bus.req_addr;
    endcase
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: errors skip memory; word stores skip the read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (acc_err)                                state_d = StResp;
          else if (bus.req_write && acc_size == SZ_WORD) state_d = StWrite;
          else                                        state_d = StRead;
        end
      end
      StRead:  state_d = write_q ? StWrite : StResp;
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request latch at accept; end of READ captures load data or merged word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_lo_q <= 2'b00;
      size_q    <= SZ_BYTE;
      signed_q  <= 1'b0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      waddr_q   <= '0;
      wword_q   <= '0;
      rdata_q   <= '0;
    end else begin
      if (accept) begin
        addr_lo_q <= acc_addr[1:0];
        size_q    <= acc_size;
        signed_q  <= bus.req_signed;
        write_q   <= bus.req_write;
        wdata_q   <= bus.req_wdata;
        err_q     <= acc_err;
        waddr_q   <= {2'b00, acc_addr[ADDRESSWIDTH-1:2]};
        wword_q   <= bus.req_wdata;
        rdata_q   <= '0;
      end
      if (state_q == StRead) begin
        if (write_q) wword_q <= st_word;
        else         rdata_q <= ld_data;
      end
    end
  end

  mem_lsu_lanes u_lanes (
    .addr_lo   (addr_lo_q),
    .size      (size_q),
    .is_signed (signed_q),
    .rd_word   (bus.mem_readData),
    .st_data   (wdata_q),
    .ld_data   (ld_data),
    .st_word   (st_word)
  );

  // Outputs; the write strobe is gated by reset so a reset edge never commits.
  always_comb begin
    bus.req_ready     = (state_q == StIdle);
    bus.resp_valid    = (state_q == StResp);
    bus.resp_rdata    = (state_q == StResp) ? rdata_q : '0;
    bus.resp_err      = (state_q == StResp) && err_q;
    bus.mem_MemRead   = (state_q == StRead);
    bus.mem_MemWrite  = (state_q == StWrite) && reset_n;
    bus.mem_address   = waddr_q;
    bus.mem_writeData = wword_q;
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a small word memory model and strobe monitor.
module tb_mem_lsu;

  logic clk;
  logic reset_n;

  mem_lsu_if #(.ADDRESSWIDTH(32), .WIDTH(32)) bus ();

  mem_lsu #(.ADDRESSWIDTH(32), .WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem [0:15];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_idx = 4'd0;
  logic [31:0] pre_data = 32'd0;
  int          commit_cnt = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          both_cnt = 0;
  logic [31:0] last_rd_addr = 32'd0;
  logic [31:0] last_wr_addr = 32'd0;
  logic [31:0] last_wr_data = 32'd0;

  assign bus.mem_readData = mem[bus.mem_address[3:0]];

  // Memory model: backdoor preload or commit on the write strobe.
  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_idx] <= pre_data;
    end else if (bus.mem_MemWrite) begin
      mem[bus.mem_address[3:0]] <= bus.mem_writeData;
      commit_cnt <= commit_cnt + 1;
    end
  end

  // Strobe monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_MemRead) begin
      rd_cnt       <= rd_cnt + 1;
      last_rd_addr <= bus.mem_address;
    end
    if (bus.mem_MemWrite) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= bus.mem_address;
      last_wr_data <= bus.mem_writeData;
    end
    if (bus.mem_MemRead && bus.mem_MemWrite) both_cnt <= both_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] data);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_idx  = idx;
    pre_data = data;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // One request; returns latency (accept edge to resp_valid), response and strobe counts.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int rd_n, output int wr_n, output int busy_rdy);
    int  rd0, wr0;
    bit  got;
    @(negedge clk);
    check_eq("ready_idle", {31'd0, bus.req_ready}, 32'd1);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat      = 0;
    rdata    = 32'd0;
    err      = 1'b0;
    busy_rdy = 0;
    got      = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (bus.req_ready) busy_rdy++;
      if (bus.resp_valid) begin
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        lat   = i;
        got   = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) check_eq("resp_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check_eq("resp_one_pulse", {31'd0, bus.resp_valid}, 32'd0);
    rd_n = rd_cnt - rd0;
    wr_n = wr_cnt - wr0;
  endtask

  int          lat, rd_n, wr_n, busy;
  logic [31:0] rdata;
  logic        err;
  int          c0, w0, r0;
  bit          seen;
  logic [5:0]  rv, pv;

  initial begin
    reset_n        = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check_eq("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check_eq("rst_strobes", {30'd0, bus.mem_MemRead, bus.mem_MemWrite}, 32'd0);
    check_eq("rst_address", bus.mem_address, 32'd0);
    check_eq("rst_wdata", bus.mem_writeData, 32'd0);
    check_eq("rst_rdata", bus.resp_rdata, 32'd0);
    reset_n = 1'b1;

    // Word store then word load.
    do_req(1'b1, 2'b10, 1'b0, 32'h0000_C004, 32'hDEAD_BEEF, lat, rdata, err, rd_n, wr_n, busy);
    check_eq("sw_lat", lat, 32'd2);
    check_eq("sw_rdata_zero", rdata, 32'd0);
    check_eq("sw_err", {31'd0, err}, 32'd0);
    check_eq("sw_wr_pulses", wr_n, 32'd1);
    check_eq("sw_rd_pulses", rd_n, 32'd0);
    check_eq("sw_addr", last_wr_addr, 32'h0000_3001);
    check_eq("sw_data", last_wr_data, 32'hDEAD_BEEF);
    check_eq("sw_mem", mem[1], 32'hDEAD_BEEF);
    check_eq("sw_busy_ready", busy, 32'd0);

    do_req(1'b0, 2'b10, 1'b0, 32'h0000_C004, 32'd0, lat, rdata, err, rd_n, wr_n, busy);
    check_eq("lw_lat", lat, 32'd2);
    check_eq("lw_rdata", rdata, 32'hDEAD_BEEF);
    check_eq("lw_rd_pulses", rd_n, 32'd1);
    check_eq("lw_wr_pulses", wr_n, 32'd0);
    check_eq("lw_addr", last_rd_addr, 32'h0000_3001);

    // Byte store read-modify-write.
    preload(4'd2, 32'h1122_3344);
    do_req(1'b1, 2'b00, 1'b0, 32'h0000_C00A, 32'h0000_00AA, lat, rdata, err, rd_n, wr_n, busy);
    check_eq("sb_lat", lat, 32'd3);
    check_eq("sb_rd_pulses", rd_n, 32'd1);
    check_eq("sb_wr_pulses", wr_n, 32'd1);
    check_eq("sb_wdata", last_wr_data, 32'h11AA_3344);
    check_eq("sb_mem", mem[2], 32'h11AA_3344);
    check_eq("sb_busy_ready", busy, 32'd0);

    // Sub-word loads and a half store.
    preload(4'd2, 32'h80FF_7F01);
    do_req(1'b0, 2'b00, 1'b1, 32'h0000_C00B, 32'd0, lat, rdata, err, rd_n, wr_n, busy);
    check_eq("lb_signed", rdata, 32'hFFFF_FF80);
    check_eq("lb_lat", lat, 32'd2);
    do_req(1'b0, 2'b00, 1'b0, 32'h0000_C00B, 32'd0, lat, rdata, err, rd_n, wr_n, busy);
    check_eq("lbu", rdata, 32'h0000_0080);
    do_req(1'b0, 2'b01, 1'b1, 32'h0000_C008, 32'd0, lat, rdata, err, rd_n, wr_n, busy);
    check_eq("lh_signed_lo", rdata, 32'h0000_7F01);
    do_req(1'b0, 2'b01, 1'b1, 32'h0000_C00A, 32'd0, lat, rdata, err, rd_n, wr_n, busy);
    check_eq("lh_signed_hi", rdata, 32'hFFFF_80FF);
    do_req(1'b1, 2'b01, 1'b0, 32'h0000_C00A, 32'h1234_BEEF, lat, rdata, err, rd_n, wr_n, busy);
    check_eq("sh_lat", lat, 32'd3);
    check_eq("sh_mem", mem[2], 32'hBEEF_7F01);

    // Misaligned and illegal-size requests.
    preload(4'd0, 32'hCAFE_F00D);
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_C001, 32'd0, lat, rdata, err, rd_n, wr_n, busy);
`ifdef MEM_LSU_ALIGN_CHECK_EN
    check_eq("mis_err", {31'd0, err}, 32'd1);
    check_eq("mis_lat", lat, 32'd1);
    check_eq("mis_strobes", rd_n + wr_n, 32'd0);
`else
    check_eq("mis_err", {31'd0, err}, 32'd0);
    check_eq("mis_lat", lat, 32'd2);
    check_eq("mis_rdata", rdata, 32'hCAFE_F00D);
    check_eq("mis_addr", last_rd_addr, 32'h0000_3000);
`endif
    do_req(1'b0, 2'b11, 1'b0, 32'h0000_C004, 32'd0, lat, rdata, err, rd_n, wr_n, busy);
`ifdef MEM_LSU_ALIGN_CHECK_EN
    check_eq("ill_err", {31'd0, err}, 32'd1);
    check_eq("ill_strobes", rd_n + wr_n, 32'd0);
`else
    check_eq("ill_err", {31'd0, err}, 32'd0);
    check_eq("ill_rdata", rdata, 32'hDEAD_BEEF);
`endif

    // Reset during the WRITE cycle of a byte store.
    preload(4'd2, 32'h1122_3344);
    c0 = commit_cnt;
    seen = 1'b0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0000_C009;
    bus.req_wdata  = 32'h0000_0055;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    seen |= bus.resp_valid;
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_wr_gate", {31'd0, bus.mem_MemWrite}, 32'd0);
    seen |= bus.resp_valid;
    @(negedge clk);
    reset_n = 1'b1;
    check_eq("rst_mid_ready", {31'd0, bus.req_ready}, 32'd1);
    seen |= bus.resp_valid;
    @(negedge clk);
    seen |= bus.resp_valid;
    check_eq("rst_mid_no_resp", {31'd0, seen}, 32'd0);
    check_eq("rst_mid_mem", mem[2], 32'h1122_3344);
    check_eq("rst_mid_commits", commit_cnt - c0, 32'd0);

    // Back-to-back loads with req_valid held high.
    @(negedge clk);
    r0 = rd_cnt;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b10;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0000_C004;
    rv = 6'd0;
    pv = 6'd0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      rv = {rv[4:0], bus.req_ready};
      pv = {pv[4:0], bus.resp_valid};
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_eq("b2b_ready", {26'd0, rv}, 32'b100100);
    check_eq("b2b_resp", {26'd0, pv}, 32'b001001);
    check_eq("b2b_reads", rd_cnt - r0, 32'd2);
    check_eq("strobes_exclusive", both_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
